// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: owns PC and IR, runs one req/ack read per ir_load,
// and flags timeouts and overlapping fetch requests with sticky status bits.
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              pc_load,
  input  logic              pc_set,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              fault,
  output logic              overrun
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         ir_d;
  logic               ir_valid_d;
  logic               fault_d;
  logic               overrun_d;
  logic [ADDR_W-1:0]  pc_d;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack takes precedence over an expiring counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ir_load) state_d = REQ;
      REQ:     if (mem_ack || (cnt_q == CNT_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    ir_d       = ir;
    ir_valid_d = 1'b0;
    fault_d    = fault;
    overrun_d  = overrun | (ir_load && (state_q != IDLE));
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (ir_load) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          cnt_d      = '0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          ir_d      = 8'h00;
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // PC update runs every cycle, independent of the fetch sequence
  always_comb begin
    pc_d = pc;
    if (pc_set) begin
      pc_d = pc_target;
    end else if (pc_load) begin
      pc_d = pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir       <= 8'h00;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      ir       <= ir_d;
      ir_valid <= ir_valid_d;
      busy     <= (state_d != IDLE);
      pc       <= pc_d;
      fault    <= fault_d;
      overrun  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios against fixed values, then random
// traffic against a transaction-level model of the fetch/PC behaviour.
module tb_instr_fetch_unit;

  localparam int unsigned TIMEOUT = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ir_load = 1'b0;
  logic       pc_load = 1'b0;
  logic       pc_set = 1'b0;
  logic [7:0] pc_target = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] ir;
  logic       ir_valid;
  logic       busy;
  logic [7:0] pc;
  logic       fault;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  // Model: a fetch is described by how long it has been outstanding
  logic [7:0] m_pc, m_ir, m_addr;
  logic       m_valid, m_fault, m_overrun;
  bit         m_outstanding;
  bit         m_finishing;
  int         m_waited;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ir_load(ir_load), .pc_load(pc_load),
    .pc_set(pc_set), .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .busy(busy), .pc(pc), .fault(fault), .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00;
    m_valid = 1'b0; m_fault = 1'b0; m_overrun = 1'b0;
    m_outstanding = 1'b0; m_finishing = 1'b0; m_waited = 0;
  endfunction

  function automatic void model_step();
    logic [7:0] old_pc;
    old_pc = m_pc;
    if (pc_set) m_pc = pc_target;
    else if (pc_load) m_pc = 8'((int'(m_pc) + 1) % 256);
    m_valid = 1'b0;
    if (m_finishing) begin
      m_finishing = 1'b0;
      if (ir_load) m_overrun = 1'b1;
    end else if (m_outstanding) begin
      if (ir_load) m_overrun = 1'b1;
      if (mem_ack) begin
        m_ir = mem_rdata; m_valid = 1'b1;
        m_outstanding = 1'b0; m_finishing = 1'b1;
      end else if (m_waited + 1 >= int'(TIMEOUT)) begin
        m_ir = 8'h00; m_fault = 1'b1;
        m_outstanding = 1'b0; m_finishing = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (ir_load) begin
      m_outstanding = 1'b1; m_addr = old_pc; m_waited = 0;
    end
  endfunction

  task automatic drive_cycle(input logic il, input logic pl, input logic ps,
                             input logic [7:0] tgt, input logic ack, input logic [7:0] rd);
    @(negedge clock);
    ir_load = il; pc_load = pl; pc_set = ps; pc_target = tgt;
    mem_ack = ack; mem_rdata = rd;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    ir_load = 1'b0; pc_load = 1'b0; pc_set = 1'b0; mem_ack = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({mem_req, mem_addr, ir, ir_valid, busy, pc, fault, overrun} !== 29'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b addr=%h ir=%h v=%b busy=%b pc=%h f=%b o=%b, want all zero",
               mem_req, mem_addr, ir, ir_valid, busy, pc, fault, overrun);
    end
  endtask

  task automatic test_basic_fetch();
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_req: got req=%b addr=%h busy=%b, want 1 00 1", mem_req, mem_addr, busy);
    end
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h00 || ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_wait%0d: got req=%b addr=%h v=%b, want 1 00 0", i, mem_req, mem_addr, ir_valid);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
    checks++;
    if (ir !== 8'h01 || ir_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got ir=%h v=%b req=%b, want 01 1 0", ir, ir_valid, mem_req);
    end
    idle_cycle();
    checks++;
    if (ir_valid !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || ir !== 8'h01) begin
      errors++;
      $display("FAIL basic_after: got v=%b busy=%b fault=%b ir=%h, want 0 0 0 01", ir_valid, busy, fault, ir);
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
    drive_cycle(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (pc !== exp_seq[i]) begin
        errors++;
        $display("FAIL pc_wrap%0d: got pc=%h, want %h", i, pc, exp_seq[i]);
      end
    end
  endtask

  task automatic test_set_vs_load();
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
    checks++;
    if (pc !== 8'h40 || mem_addr !== 8'h10 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL set_vs_load: got pc=%h addr=%h req=%b, want 40 10 1", pc, mem_addr, mem_req);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77);
    idle_cycle();
  endtask

  task automatic test_timeout();
    int req_cycles;
    bit saw_valid;
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    req_cycles = mem_req ? 1 : 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      idle_cycle();
      if (mem_req) req_cycles++;
      if (ir_valid) saw_valid = 1'b1;
    end
    checks++;
    if (req_cycles != int'(TIMEOUT) || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len: got %0d req cycles (req=%b), want %0d", req_cycles, mem_req, TIMEOUT);
    end
    checks++;
    if (ir !== 8'h00 || saw_valid || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: got ir=%h valid_seen=%b fault=%b, want 00 0 1", ir, saw_valid, fault);
    end
    idle_cycle();
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h9C);
    idle_cycle();
    checks++;
    if (ir !== 8'h9C || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got ir=%h fault=%b, want 9c 1", ir, fault);
    end
  endtask

  task automatic test_overrun_boundary();
    int pulses;
    bit req_again;
    apply_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++;
    if (overrun !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got overrun=%b req=%b, want 1 1", overrun, mem_req);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
    pulses = ir_valid ? 1 : 0;
    req_again = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hEE);
      if (ir_valid) pulses++;
      if (mem_req) req_again = 1'b1;
    end
    checks++;
    if (pulses != 1 || req_again || ir !== 8'h5A) begin
      errors++;
      $display("FAIL overrun_single: got pulses=%0d req_again=%b ir=%h, want 1 0 5a", pulses, req_again, ir);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) idle_cycle();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL boundary_hold: got req=%b, want 1 before 15th wait cycle", mem_req);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC3);
    checks++;
    if (ir !== 8'hC3 || ir_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL boundary_ack: got ir=%h v=%b fault=%b, want c3 1 0", ir, ir_valid, fault);
    end
    idle_cycle();
  endtask

  task automatic test_reset_midfetch();
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    idle_cycle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got req=%b busy=%b v=%b pc=%h, want 0 0 0 00", mem_req, busy, ir_valid, pc);
    end
    @(negedge clock);
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hAA);
    idle_cycle();
    checks++;
    if (ir !== 8'h00 || ir_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: got ir=%h v=%b busy=%b, want 00 0 0", ir, ir_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [28:0] got, want;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
                  8'($urandom), ($urandom % 7) == 0, 8'($urandom));
      got  = {mem_req, mem_addr, ir, ir_valid, busy, pc, fault, overrun};
      want = {m_outstanding, m_addr, m_ir, m_valid, m_outstanding | m_finishing,
              m_pc, m_fault, m_overrun};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h, want %h (req,addr,ir,valid,busy,pc,fault,overrun)",
                 i, got, want);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_fetch();
    test_pc_wrap();
    test_set_vs_load();
    test_timeout();
    test_overrun_boundary();
    test_reset_midfetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Responder side of the control-unit fetch interface: executes the control unit's `ir_load`/`pc_load` requests against instruction memory.
- Owns the program counter (PC) and the instruction register (IR); issues a req/ack read to instruction memory on `ir_load`.
- Presents the fetched byte on `ir` for the control unit's DECODE state.
- Also accepts direct PC writes for JMP/CALL/RET/GOTO/JZ/JNZ targets, and flags protocol faults.

Parameters:
- ADDR_W, 8, width of PC and memory address.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, max cycles waiting for mem_ack before aborting (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- ir_load  in  1  control-unit pulse: start instruction fetch at current PC.
- pc_load  in  1  control-unit pulse: PC <= PC + 1.
- pc_set  in  1  load PC from pc_target (branch/call/return).
- pc_target  in  ADDR_W  branch target.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address, stable while mem_req=1.
- mem_ack  in  1  memory response strobe; mem_rdata valid same cycle.
- mem_rdata  in  8  instruction byte.
- ir  out  8  instruction register to control unit.
- ir_valid  out  1  one-cycle pulse when ir updated by successful fetch.
- busy  out  1  fetch in progress (state != IDLE).
- pc  out  ADDR_W  current program counter.
- fault  out  1  sticky: timeout occurred.
- overrun  out  1  sticky: ir_load received while busy.

Behaviour:
- Reset (async, reset=0) forces every output immediately: pc=RESET_PC, ir=8'h00, mem_req=0, mem_addr=0, ir_valid=0, busy=0, fault=0, overrun=0; state=IDLE; timeout counter=0. Any in-flight fetch is abandoned with no ack expected.
- States:
  - IDLE: on ir_load=1 -> REQ; mem_addr<=pc, mem_req<=1 registered (visible the next cycle), counter<=0.
  - REQ: mem_req=1, mem_addr held.
    - mem_ack=1 -> DONE; ir<=mem_rdata, mem_req<=0.
    - Else if counter==TIMEOUT-1 -> DONE; mem_req<=0, ir<=8'h00, fault<=1.
    - Else counter++.
  - DONE: ir_valid=1 only if the fetch completed by ack; -> IDLE next cycle.
- Latency: ir_load at cycle N -> mem_req high at N+1. Ack sampled at cycle M -> ir updated at M+1 and ir_valid high at M+1, one cycle only.
- ir holds its value until the next successful fetch or a timeout.
- An ack arriving at the same edge the counter expires counts as success: ack wins, no fault.
- mem_ack while in IDLE or DONE is ignored.
- mem_addr is latched at fetch start; PC updates during a fetch do not alter mem_addr.
- PC update, independent of the fetch FSM, evaluated every cycle:
  - pc_set=1 -> pc<=pc_target (priority over pc_load).
  - Else pc_load=1 -> pc<=pc+1, modulo 2^ADDR_W; all-ones wraps to 0.
  - Else hold.
- ir_load in REQ or DONE is ignored, no queueing, and sets overrun<=1.
- ir_load on the same cycle the FSM enters IDLE from DONE is not accepted; only ir_load sampled in IDLE starts a fetch.
- fault and overrun clear only on reset.
- busy=1 in REQ and DONE.

Test Plan:
- Basic fetch: reset, pulse ir_load, memory acks after 2 wait cycles with rdata=8'h01 -> mem_addr=0x00 while mem_req=1; ir=8'h01 and ir_valid single pulse one cycle after ack; busy low afterwards; fault=0.
- PC step and wrap: pc_set with pc_target=8'hFE, then three pc_load pulses -> pc sequence FE, FF, 00, 01.
- Set vs load: pc_set=1 (target 8'h40) and pc_load=1 same cycle with pc=8'h10 -> pc=8'h40. Fetch in progress from 8'h10 keeps mem_addr=8'h10.
- Timeout: ir_load, never ack -> mem_req high exactly TIMEOUT(15) cycles, then low. ir=8'h00, no ir_valid, fault=1 and stays 1 through a later successful fetch.
- Overrun and boundary: second ir_load during REQ -> overrun=1, only one ack consumed, single ir_valid. Ack on the 15th wait cycle -> success, fault=0.
- Reset mid-fetch: drop reset while mem_req=1 -> mem_req, busy, ir_valid immediately 0, pc=RESET_PC. A late mem_ack after reset release does not change ir.
